// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the F6 engine state type.
package lenet_pkg;

  localparam int F6_IN  = 120;
  localparam int F6_OUT = 84;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } f6_state_t;

endpackage

// File: rtl/f6_mac_lane.sv
// One F6 neuron lane: signed 8x8 multiply into a 24-bit accumulator.
module f6_mac_lane
  import lenet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] x,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = $signed(w) * $signed(x);

  // Clear has priority so a new pass never inherits a stale sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/f6_fc_engine.sv
// LeNet F6 fully-connected engine: 120-step MAC over 84 lanes, then
// requantized results streamed out over valid/ready.
module f6_fc_engine
  import lenet_pkg::*;
#(
  parameter int SHIFT   = 7,
  parameter int RELU_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ADDR_W-1:0]        w6_raddr,
  input  logic [F6_OUT*DATA_W-1:0] w6_rdata,
  output logic [ADDR_W-1:0]        x_raddr,
  input  logic [DATA_W-1:0]        x_rdata,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_idx,
  output logic [DATA_W-1:0]        out_data,
  output logic                     done
);

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int RND_I  = (SHIFT > 0) ? (1 << RND_SH) : 0;
  localparam logic signed [ACC_W:0] SAT_MAX = 127;
  localparam logic signed [ACC_W:0] SAT_MIN = -128;

  f6_state_t          state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, idx_q;
  logic               mac_vld, acc_clr, last_addr, last_idx, out_fire;
  logic [ACC_W-1:0]   acc [F6_OUT];
  logic signed [ACC_W:0] acc_sel, rounded, shifted;
  logic [DATA_W-1:0]  sat;

  assign last_addr = (addr_q == ADDR_W'(F6_IN - 1));
  assign last_idx  = (idx_q == ADDR_W'(F6_OUT - 1));
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_MAC;
      ST_MAC:   if (last_addr) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_OUT;
      ST_OUT:   if (out_fire && last_idx) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_OUT);
    done      = (state == ST_DONE);
    acc_clr   = (state == ST_IDLE) && start;
  end

  // The address register doubles as the MAC step counter k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      mac_vld <= 1'b0;
    end else begin
      mac_vld <= (state == ST_MAC);
      if (acc_clr)
        addr_q <= '0;
      else if (state == ST_MAC && !last_addr)
        addr_q <= addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx_q <= '0;
    else if (acc_clr)
      idx_q <= '0;
    else if (out_fire)
      idx_q <= last_idx ? '0 : idx_q + 1'b1;
  end

  for (genvar j = 0; j < F6_OUT; j++) begin : g_lane
    f6_mac_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (mac_vld),
      .w   (w6_rdata[DATA_W*j +: DATA_W]),
      .x   (x_rdata),
      .acc (acc[j])
    );
  end

  // Round-half-up, arithmetic shift, saturate to int8, optional ReLU.
  always_comb begin
    acc_sel = {acc[idx_q][ACC_W-1], acc[idx_q]};
    rounded = acc_sel + (ACC_W+1)'(RND_I);
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_MAX)      sat = 8'h7F;
    else if (shifted < SAT_MIN) sat = 8'h80;
    else                        sat = shifted[DATA_W-1:0];
    if (RELU_EN != 0 && sat[DATA_W-1]) sat = '0;
  end

  assign w6_raddr = addr_q;
  assign x_raddr  = addr_q;
  assign out_idx  = idx_q;
  assign out_data = out_valid ? sat : '0;

endmodule

// File: tb/tb_f6_fc_engine.sv
// Bench for f6_fc_engine: three parameterisations run in lockstep against
// an arithmetic reference of the F6 layer.
module tb_f6_fc_engine;
  import lenet_pkg::*;

  localparam int NDUT  = 3;
  localparam int LIMIT = 600;

  typedef struct {
    int w_mode;     // 0 rand, 1 small, 2 all 127, 3 all -128, 4 impulse row, 5 keep
    int x_mode;     // 0 rand, 1 small, 2 all 127, 3 impulse, 5 keep
    int rdy_mode;   // 0 always, 1 stall idx 5 for 10 cycles, 2 random
    int glitch;     // pulse start during MAC and OUT
    int abort_cyc;  // assert reset in this cycle (0 = none)
    int exp_kind;   // 0 model only, 1 constant outputs, 2 u0 data == idx
    int e0, e7, er;
    int exp_done;   // cycle done must pulse (0 = don't care)
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, out_ready;
  logic [6:0]   w_ra [NDUT], x_ra [NDUT], idx_o [NDUT];
  logic [671:0] w_rd [NDUT];
  logic [7:0]   x_rd [NDUT], data_o [NDUT];
  logic         busy_o [NDUT], valid_o [NDUT], done_o [NDUT];

  logic signed [7:0] wmem [F6_IN][F6_OUT];
  logic signed [7:0] xmem [F6_IN];
  int exp_acc [F6_OUT];
  int tests, fails;
  vec_t vecs [9];

  f6_fc_engine #(.SHIFT(0), .RELU_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .w6_raddr(w_ra[0]), .w6_rdata(w_rd[0]),
    .x_raddr(x_ra[0]), .x_rdata(x_rd[0]), .busy(busy_o[0]), .out_valid(valid_o[0]),
    .out_ready(out_ready), .out_idx(idx_o[0]), .out_data(data_o[0]), .done(done_o[0]));
  f6_fc_engine #(.SHIFT(7), .RELU_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .w6_raddr(w_ra[1]), .w6_rdata(w_rd[1]),
    .x_raddr(x_ra[1]), .x_rdata(x_rd[1]), .busy(busy_o[1]), .out_valid(valid_o[1]),
    .out_ready(out_ready), .out_idx(idx_o[1]), .out_data(data_o[1]), .done(done_o[1]));
  f6_fc_engine #(.SHIFT(7), .RELU_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .w6_raddr(w_ra[2]), .w6_rdata(w_rd[2]),
    .x_raddr(x_ra[2]), .x_rdata(x_rd[2]), .busy(busy_o[2]), .out_valid(valid_o[2]),
    .out_ready(out_ready), .out_idx(idx_o[2]), .out_data(data_o[2]), .done(done_o[2]));

  // Synchronous ROM / feature buffer, one read port per engine.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      for (int j = 0; j < F6_OUT; j++) w_rd[d][8*j +: 8] <= wmem[w_ra[d]][j];
      x_rd[d] <= xmem[x_ra[d]];
    end
  end

  function automatic int shift_of(int d);
    return (d == 0) ? 0 : 7;
  endfunction

  function automatic int model_out(int acc, int shift, bit relu);
    int dv, num, q;
    dv  = 1 << shift;
    num = acc + ((shift > 0) ? dv / 2 : 0);
    q   = num / dv;
    if (num < 0 && (num % dv) != 0) q = q - 1;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return q;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s u%0d w6_raddr", tag, d), int'(w_ra[d]), 0);
      checkOutput($sformatf("%s u%0d x_raddr", tag, d), int'(x_ra[d]), 0);
      checkOutput($sformatf("%s u%0d busy", tag, d), int'(busy_o[d]), 0);
      checkOutput($sformatf("%s u%0d out_valid", tag, d), int'(valid_o[d]), 0);
      checkOutput($sformatf("%s u%0d out_idx", tag, d), int'(idx_o[d]), 0);
      checkOutput($sformatf("%s u%0d out_data", tag, d), int'(data_o[d]), 0);
      checkOutput($sformatf("%s u%0d done", tag, d), int'(done_o[d]), 0);
    end
  endtask

  task automatic fill_mem(input int wm, input int xm);
    for (int k = 0; k < F6_IN; k++) begin
      for (int j = 0; j < F6_OUT; j++) begin
        case (wm)
          1:       wmem[k][j] = 8'(int'($urandom_range(0, 15)) - 8);
          2:       wmem[k][j] = 8'sd127;
          3:       wmem[k][j] = 8'h80;
          4:       wmem[k][j] = (k == 0) ? 8'(j) : 8'($urandom_range(0, 255));
          default: wmem[k][j] = 8'($urandom_range(0, 255));
        endcase
      end
      case (xm)
        1:       xmem[k] = 8'(int'($urandom_range(0, 15)) - 8);
        2:       xmem[k] = 8'sd127;
        3:       xmem[k] = (k == 0) ? 8'sd1 : 8'sd0;
        default: xmem[k] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int  exp_i, last_hs, first_valid, expc, exp_addr;
    bit  exp_valid, exp_done, finished;
    bit  stalled;
    logic [6:0] held_idx [NDUT];
    logic [7:0] held_data [NDUT];
    if (v.w_mode != 5) fill_mem(v.w_mode, v.x_mode);
    for (int j = 0; j < F6_OUT; j++) begin
      exp_acc[j] = 0;
      for (int k = 0; k < F6_IN; k++) exp_acc[j] += int'(wmem[k][j]) * int'(xmem[k]);
    end
    exp_i = 0; last_hs = -10; first_valid = -1; finished = 0; stalled = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (v.abort_cyc != 0 && n == v.abort_cyc) begin
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        finished = 1;
        break;
      end
      if (n >= 1 && n <= 123) begin
        exp_addr = (n <= 120) ? n - 1 : 119;
        for (int d = 0; d < NDUT; d++) begin
          checkOutput($sformatf("u%0d w6_raddr c%0d", d, n), int'(w_ra[d]), exp_addr);
          checkOutput($sformatf("u%0d x_raddr c%0d", d, n), int'(x_ra[d]), exp_addr);
        end
      end
      if (n == 1) checkOutput("busy after start", int'(busy_o[0]), 1);
      if (valid_o[0] && first_valid < 0) begin
        first_valid = n;
        checkOutput("first out_valid cycle", n, 122);
      end
      exp_valid = (n >= 122) && (exp_i < F6_OUT);
      for (int d = 0; d < NDUT; d++) begin
        checkOutput($sformatf("u%0d out_valid c%0d", d, n), int'(valid_o[d]), int'(exp_valid));
        if (stalled) begin
          checkOutput($sformatf("u%0d held idx c%0d", d, n), int'(idx_o[d]), int'(held_idx[d]));
          checkOutput($sformatf("u%0d held data c%0d", d, n), int'(data_o[d]), int'(held_data[d]));
        end
      end
      if (exp_valid && out_ready) begin
        for (int d = 0; d < NDUT; d++) begin
          checkOutput($sformatf("u%0d out_idx", d), int'(idx_o[d]), exp_i);
          checkOutput($sformatf("u%0d out_data idx%0d", d, exp_i), int'($signed(data_o[d])),
                      model_out(exp_acc[exp_i], shift_of(d), d == 2));
          expc = (d == 0) ? v.e0 : (d == 1) ? v.e7 : v.er;
          if (v.exp_kind == 1)
            checkOutput($sformatf("u%0d const data idx%0d", d, exp_i), int'($signed(data_o[d])), expc);
        end
        if (v.exp_kind == 2)
          checkOutput($sformatf("impulse data idx%0d", exp_i), int'($signed(data_o[0])), exp_i);
        exp_i++;
        last_hs = n;
      end
      stalled = exp_valid && !out_ready;
      for (int d = 0; d < NDUT; d++) begin
        held_idx[d]  = idx_o[d];
        held_data[d] = data_o[d];
      end
      exp_done = (exp_i == F6_OUT) && (n == last_hs + 1);
      for (int d = 0; d < NDUT; d++)
        checkOutput($sformatf("u%0d done c%0d", d, n), int'(done_o[d]), int'(exp_done));
      if (v.exp_done != 0 && n == v.exp_done) checkOutput("done at table cycle", int'(done_o[0]), 1);
      if (exp_done) checkOutput("busy during done", int'(busy_o[0]), 1);
      if (exp_i == F6_OUT && n == last_hs + 2) begin
        for (int d = 0; d < NDUT; d++)
          checkOutput($sformatf("u%0d busy after done", d), int'(busy_o[d]), 0);
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      start = (v.glitch != 0) && (n + 1 == 50 || n + 1 == 150);
      case (v.rdy_mode)
        1:       out_ready = !((n + 1) >= 127 && (n + 1) <= 136);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!finished) checkOutput("pass completion within cycle budget", 0, 1);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    vecs[0] = '{4, 3, 0, 0, 0,  2, 0,    0,    0,   206};
    vecs[1] = '{2, 2, 0, 0, 0,  1, 127,  127,  127, 206};
    vecs[2] = '{3, 2, 0, 0, 0,  1, -128, -128, 0,   206};
    vecs[3] = '{0, 0, 1, 0, 0,  0, 0,    0,    0,   216};
    vecs[4] = '{1, 1, 0, 1, 0,  0, 0,    0,    0,   206};
    vecs[5] = '{0, 1, 0, 0, 60, 0, 0,    0,    0,   0};
    vecs[6] = '{5, 5, 0, 0, 0,  0, 0,    0,    0,   206};
    vecs[7] = '{0, 1, 2, 0, 0,  0, 0,    0,    0,   0};
    vecs[8] = '{1, 0, 0, 1, 0,  0, 0,    0,    0,   206};
    fill_mem(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle busy after reset release", int'(busy_o[0]), 0);
    for (int t = 0; t < 9; t++) applyStimulus(vecs[t]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
